// File: rtl/pp_loop_flow_ctrl.sv
// Loop-pipeline flow control: start/ready/done handshake between a parent block and its loop body,
// plus a signed 9x8 multiplier. Define PP_LOOP_FLOW_CTRL_MUL_REG_EN to register mul_p (1-cycle latency).
module pp_loop_flow_ctrl (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_ready,
  output logic               ap_done,
  output logic               ap_start_int,
  output logic               ap_loop_init,
  input  logic               ap_ready_int,
  input  logic               ap_loop_exit_ready,
  input  logic               ap_loop_exit_done,
  output logic               ap_continue_int,
  input  logic               ap_done_int,
  input  logic signed [8:0]  mul_a,
  input  logic signed [7:0]  mul_b,
  output logic signed [16:0] mul_p
);

  logic               r_loop_init_q;
  logic               r_done_cache;
  logic signed [16:0] w_a;
  logic signed [16:0] w_b;
  logic signed [16:0] w_prod;
  logic               w_unused;

  // Pipeline-side done is redundant with ap_loop_exit_done; kept only for interface compatibility.
  assign w_unused = ap_done_int;

  assign ap_start_int    = ap_start;
  assign ap_continue_int = 1'b1;
  assign ap_ready        = ap_loop_exit_ready;
  assign ap_loop_init    = r_loop_init_q & ap_start;
  // A live exit or a new start overrides the cached completion.
  assign ap_done         = (ap_loop_exit_done | ap_start) ? ap_loop_exit_done : r_done_cache;

  // Exit re-arms the first-iteration flag even if an iteration is accepted that same cycle.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_loop_init_q <= 1'b1;
      r_done_cache  <= 1'b0;
    end else begin
      if (ap_loop_exit_ready)
        r_loop_init_q <= 1'b1;
      else if (ap_ready_int)
        r_loop_init_q <= 1'b0;
      if (ap_start)
        r_done_cache <= 1'b0;
      else if (ap_loop_exit_done)
        r_done_cache <= 1'b1;
    end
  end

  // Operands sign-extended to the product width; the full-range product fits exactly in 17 bits.
  assign w_a    = {{8{mul_a[8]}}, mul_a};
  assign w_b    = {{9{mul_b[7]}}, mul_b};
  assign w_prod = w_a * w_b;

`ifdef PP_LOOP_FLOW_CTRL_MUL_REG_EN
  logic signed [16:0] r_mul_p;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_mul_p <= '0;
    else        r_mul_p <= w_prod;
  end
  assign mul_p = r_mul_p;
`else
  assign mul_p = w_prod;
`endif

endmodule

// File: tb/tb_pp_loop_flow_ctrl.sv
// Self-checking bench for pp_loop_flow_ctrl: directed handshake scenarios, multiplier vectors
// and randomized traffic against an event-level reference model.
module tb_pp_loop_flow_ctrl;

  logic               ap_clk;
  logic               ap_rst, ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done, ap_done_int;
  logic signed [8:0]  mul_a;
  logic signed [7:0]  mul_b;
  logic               ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int;
  logic signed [16:0] mul_p;

  int ncmp = 0;
  int nfail = 0;

  // Reference model state: "first iteration pending", "completion seen since last start", latched product.
  bit          m_first;
  bit          m_finished;
  logic [16:0] m_prod_q;

  pp_loop_flow_ctrl dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_start_int(ap_start_int), .ap_loop_init(ap_loop_init), .ap_ready_int(ap_ready_int),
    .ap_loop_exit_ready(ap_loop_exit_ready), .ap_loop_exit_done(ap_loop_exit_done),
    .ap_continue_int(ap_continue_int), .ap_done_int(ap_done_int),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic [16:0] prod_now();
    int p;
    p = int'(mul_a) * int'(mul_b);
    return p[16:0];
  endfunction

  function automatic logic e_init();
    return m_first && ap_start;
  endfunction

  function automatic logic e_done();
    // A start clears any earlier completion; a live exit always shows.
    return ap_loop_exit_done || (m_finished && !ap_start);
  endfunction

  function automatic logic [16:0] e_mul();
`ifdef PP_LOOP_FLOW_CTRL_MUL_REG_EN
    return m_prod_q;
`else
    return prod_now();
`endif
  endfunction

  // Drive inputs just after the rising edge, then move to the sampling point mid-cycle.
  task automatic apply(input logic r, input logic s, input logic ri, input logic er, input logic ed);
    ap_rst = r; ap_start = s; ap_ready_int = ri; ap_loop_exit_ready = er; ap_loop_exit_done = ed;
    ap_done_int = $urandom_range(0, 1);
    #3;
  endtask

  task automatic clk_step();
    bit n_first, n_finished;
    logic [16:0] n_prod;
    if (ap_rst) begin
      n_first = 1; n_finished = 0; n_prod = '0;
    end else begin
      n_first    = ap_loop_exit_ready ? 1'b1 : (ap_ready_int ? 1'b0 : m_first);
      n_finished = ap_start ? 1'b0 : (m_finished | ap_loop_exit_done);
      n_prod     = prod_now();
    end
    @(posedge ap_clk);
    m_first = n_first; m_finished = n_finished; m_prod_q = n_prod;
    #1;
  endtask

  task automatic test_reset();
    mul_a = 0; mul_b = 0;
    apply(1, 0, 0, 0, 0);
    clk_step();
    apply(1, 0, 0, 1, 1);
    ncmp++; if (ap_loop_init !== 1'b0) begin nfail++; $display("FAIL rst_init got %b exp 0", ap_loop_init); end
    ncmp++; if (ap_done !== 1'b1) begin nfail++; $display("FAIL rst_done_follow got %b exp 1", ap_done); end
    ncmp++; if (ap_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready got %b exp 1", ap_ready); end
    apply(1, 0, 0, 0, 0);
    ncmp++; if (ap_done !== 1'b0) begin nfail++; $display("FAIL rst_done_cache got %b exp 0", ap_done); end
    ncmp++; if (mul_p !== e_mul()) begin nfail++; $display("FAIL rst_mul got %h exp %h", mul_p, e_mul()); end
    clk_step();
    apply(0, 1, 0, 0, 0);
    ncmp++; if (ap_loop_init !== 1'b1) begin nfail++; $display("FAIL start_init got %b exp 1", ap_loop_init); end
    ncmp++; if (ap_start_int !== 1'b1) begin nfail++; $display("FAIL start_int got %b exp 1", ap_start_int); end
    ncmp++; if (ap_continue_int !== 1'b1) begin nfail++; $display("FAIL continue got %b exp 1", ap_continue_int); end
    clk_step();
  endtask

  task automatic test_loop_init();
    apply(0, 1, 1, 0, 0);
    ncmp++; if (ap_loop_init !== 1'b1) begin nfail++; $display("FAIL li_first got %b exp 1", ap_loop_init); end
    clk_step();
    apply(0, 1, 0, 0, 0);
    ncmp++; if (ap_loop_init !== 1'b0) begin nfail++; $display("FAIL li_cleared got %b exp 0", ap_loop_init); end
    clk_step();
    apply(0, 1, 0, 1, 0);
    ncmp++; if (ap_ready !== 1'b1) begin nfail++; $display("FAIL li_ready got %b exp 1", ap_ready); end
    clk_step();
    apply(0, 1, 0, 0, 0);
    ncmp++; if (ap_loop_init !== 1'b1) begin nfail++; $display("FAIL li_rearm got %b exp 1", ap_loop_init); end
    ncmp++; if (ap_ready !== 1'b0) begin nfail++; $display("FAIL li_ready_low got %b exp 0", ap_ready); end
    clk_step();
  endtask

  task automatic test_done_sticky();
    apply(0, 0, 0, 0, 1);
    ncmp++; if (ap_done !== 1'b1) begin nfail++; $display("FAIL dn_pulse got %b exp 1", ap_done); end
    clk_step();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0);
      ncmp++; if (ap_done !== 1'b1) begin nfail++; $display("FAIL dn_hold%0d got %b exp 1", i, ap_done); end
      clk_step();
    end
    apply(0, 1, 0, 0, 0);
    ncmp++; if (ap_done !== 1'b0) begin nfail++; $display("FAIL dn_start_clr got %b exp 0", ap_done); end
    clk_step();
    apply(0, 0, 0, 0, 0);
    ncmp++; if (ap_done !== 1'b0) begin nfail++; $display("FAIL dn_after_start got %b exp 0", ap_done); end
    clk_step();
  endtask

  task automatic test_priority();
    apply(0, 1, 1, 1, 0);
    clk_step();
    apply(0, 1, 0, 0, 0);
    ncmp++; if (ap_loop_init !== 1'b1) begin nfail++; $display("FAIL pri_exit_wins got %b exp 1", ap_loop_init); end
    clk_step();
    apply(0, 1, 0, 0, 1);
    ncmp++; if (ap_done !== 1'b1) begin nfail++; $display("FAIL pri_done_live got %b exp 1", ap_done); end
    clk_step();
    apply(0, 0, 0, 0, 0);
    ncmp++; if (ap_done !== 1'b0) begin nfail++; $display("FAIL pri_start_wins got %b exp 0", ap_done); end
    clk_step();
  endtask

  task automatic test_mid_reset();
    apply(0, 1, 1, 0, 0);
    clk_step();
    apply(0, 0, 0, 0, 1);
    clk_step();
    apply(0, 0, 0, 0, 0);
    ncmp++; if (ap_done !== 1'b1) begin nfail++; $display("FAIL mr_pre_done got %b exp 1", ap_done); end
    apply(0, 1, 0, 0, 0);
    ncmp++; if (ap_loop_init !== 1'b0) begin nfail++; $display("FAIL mr_pre_init got %b exp 0", ap_loop_init); end
    ap_start = 0;
    ap_rst = 1;
    clk_step();
    apply(0, 0, 0, 0, 0);
    ncmp++; if (ap_done !== 1'b0) begin nfail++; $display("FAIL mr_done_clr got %b exp 0", ap_done); end
    apply(0, 1, 0, 0, 0);
    ncmp++; if (ap_loop_init !== 1'b1) begin nfail++; $display("FAIL mr_init_set got %b exp 1", ap_loop_init); end
    ncmp++; if (ap_done !== 1'b0) begin nfail++; $display("FAIL mr_done_start got %b exp 0", ap_done); end
    clk_step();
  endtask

  task automatic test_mul_vectors();
    logic signed [8:0]  va [4] = '{-9'sd256, 9'sd255, -9'sd1, 9'sd0};
    logic signed [7:0]  vb [4] = '{-8'sd128, 8'sd127, 8'sd1, -8'sd128};
    logic [16:0]        vp [4] = '{17'h08000, 17'd32385, 17'h1FFFF, 17'h00000};
    for (int i = 0; i < 4; i++) begin
      mul_a = va[i]; mul_b = vb[i];
      apply(0, 0, 0, 0, 0);
`ifdef PP_LOOP_FLOW_CTRL_MUL_REG_EN
      clk_step();
      apply(0, 0, 0, 0, 0);
`endif
      ncmp++; if (mul_p !== vp[i]) begin nfail++; $display("FAIL mul_vec%0d got %h exp %h", i, mul_p, vp[i]); end
      clk_step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      mul_a = 9'($urandom); mul_b = 8'($urandom);
      apply(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      ncmp++; if (ap_loop_init !== e_init()) begin nfail++; $display("FAIL rnd_init@%0d got %b exp %b", i, ap_loop_init, e_init()); end
      ncmp++; if (ap_done !== e_done()) begin nfail++; $display("FAIL rnd_done@%0d got %b exp %b", i, ap_done, e_done()); end
      ncmp++; if (ap_ready !== ap_loop_exit_ready) begin nfail++; $display("FAIL rnd_ready@%0d got %b exp %b", i, ap_ready, ap_loop_exit_ready); end
      ncmp++; if (ap_start_int !== ap_start) begin nfail++; $display("FAIL rnd_start_int@%0d got %b exp %b", i, ap_start_int, ap_start); end
      ncmp++; if (mul_p !== e_mul()) begin nfail++; $display("FAIL rnd_mul@%0d got %h exp %h", i, mul_p, e_mul()); end
      clk_step();
    end
  endtask

  initial begin
    m_first = 1; m_finished = 0; m_prod_q = '0;
    ap_rst = 1; ap_start = 0; ap_ready_int = 0; ap_loop_exit_ready = 0; ap_loop_exit_done = 0;
    ap_done_int = 0; mul_a = 0; mul_b = 0;
    @(posedge ap_clk); #1;
    test_reset();
    test_loop_init();
    test_done_sticky();
    test_priority();
    test_mid_reset();
    test_mul_vectors();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
